fir_out_buffer: RTL and testbench
=================================

// Module: fir_out_buffer
// PURPOSE
//   Read-side companion of fir_filter. Captures the Yout sample stream (one signed 16-bit
//   sample per Clk), optionally decimates it, and buffers it in a FIFO. A downstream
//   consumer drains the FIFO over a valid/ready handshake.
//   Also tracks a sticky overflow flag and the peak sample magnitude for bring-up/debug.
// PARAMETERS
//   DW     16  sample width; matches fir_filter Yout
//   DEPTH  8   FIFO entries; power of 2, >=2
//   DECIM  1   keep 1 of every DECIM accepted samples (1 = no decimation); >=1
// PORTS
//   Clk        in   1          clock; all logic on rising edge
//   Rst_n      in   1          asynchronous active-low reset
//   Yin        in   DW signed  sample from fir_filter Yout
//   In_en      in   1          Yin valid this cycle; tie high for a free-running filter
//   Dout       out  DW signed  FIFO head sample
//   Dout_valid out  1          Dout holds a sample
//   Dout_ready in   1          consumer accepts Dout this cycle
//   Level      out  log2(DEPTH)+1  occupied entries, 0..DEPTH
//   Overflow   out  1          sticky: a kept sample was dropped because the FIFO was full
//   Peak       out  DW unsigned  max |sample| written since reset/clear
//   Clr        in   1          sync clear of Overflow and Peak
// BEHAVIOUR
//   Reset (Rst_n=0, async): pointers, Level, decim count, Overflow, Peak, Dout = 0;
//     Dout_valid = 0. Leaving reset is synchronous to Clk.
//   Decimation: count increments on In_en, wraps at DECIM-1. Sample kept ("push") when
//     In_en && count==DECIM-1. In_en=0 holds count.
//   FIFO: first-word fall-through. Dout_valid = (Level!=0). Dout = head entry.
//     pop = Dout_valid && Dout_ready.
//     Push latency: sample on Yin at edge N is visible on Dout after edge N (if empty).
//   Boundaries:
//     - push while full and no pop: sample dropped; Overflow<=1; FIFO unchanged.
//     - push and pop same cycle while full: both happen; Level stays DEPTH; no overflow.
//     - push and pop same cycle while empty: pop not possible (valid=0); push only.
//     - Dout_ready while empty: ignored.
//     - pointers wrap modulo DEPTH; Level never exceeds DEPTH or goes below 0.
//   Dout is stable while Dout_valid && !Dout_ready.
//   Peak: on each accepted push, Peak <= max(Peak, |Yin|).
//     |-2^(DW-1)| = 2^(DW-1) is exact in DW-bit unsigned.
//     Dropped samples still update Peak.
//   Clr: Overflow<=0, Peak<=0 next edge.
//     A push in the same cycle is applied after the clear: Peak = |Yin|,
//     Overflow = 1 if that push is dropped. Clr does not touch the FIFO.
// STRUCTURE
//   Shared package fir_pkg: DW (=16, also used by fir_filter), sample typedef
//     (signed [DW-1:0]), abs helper function.
//   Sub-module fir_sync_fifo (DW, DEPTH): FWFT storage, pointers, Level, full/empty.
//   Decimator, overflow and peak logic in the top.
// TESTING
//   1 Reset: Rst_n low mid-stream with 3 entries queued
//     -> Level=0, Dout_valid=0, Overflow=0, Peak=0 immediately (async).
//   2 Passthrough, DECIM=1, Dout_ready=1, Yin = -3,1,0,-2,-1,4,-5,6
//     -> Dout shows the same sequence 1 cycle later; Peak ends at 6.
//   3 Fill, DEPTH=8, Dout_ready=0, 10 pushes of 1..10
//     -> Level=8, Overflow=1 after the 9th push; drain yields 1..8 only.
//   4 Full with simultaneous push/pop (Dout_ready=1 at Level=8)
//     -> Level stays 8, Overflow stays 0, order preserved.
//   5 DECIM=3, In_en=1, Yin=0..8 -> FIFO receives 2,5,8.
//     With In_en low for 2 cycles mid-run, the phase is held.
//   6 Yin=-32768 -> Peak=32768. Clr same cycle as push of 7 -> Peak=7, Overflow=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Types and helpers shared between fir_filter and its read-side companions.
package fir_pkg;

  localparam int DW = 16;

  typedef logic signed [DW-1:0] sample_t;

  // The most negative sample maps to 2^(DW-1), which still fits in DW unsigned bits.
  function automatic logic [DW-1:0] abs_sample(input sample_t s);
    logic [DW-1:0] u;
    u = s;
    return s[DW-1] ? ((~u) + DW'(1)) : u;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// First-word fall-through FIFO: the head entry is presented combinationally on dout_o.
module fir_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              din_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              dout_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          wr_en, rd_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(wr_en) - LW'(rd_en);
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

  // Storage is not reset, so the output is forced to zero whenever nothing is queued.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fir_out_buffer.sv
// Captures fir_filter output, optionally decimates it, and queues it for a valid/ready
// consumer; also keeps a sticky overflow flag and the peak sample magnitude.
module fir_out_buffer
  import fir_pkg::*;
#(
  parameter int DW    = fir_pkg::DW,
  parameter int DEPTH = 8,
  parameter int DECIM = 1
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic signed [DW-1:0]    Yin,
  input  logic                    In_en,
  output logic signed [DW-1:0]    Dout,
  output logic                    Dout_valid,
  input  logic                    Dout_ready,
  output logic [$clog2(DEPTH):0]  Level,
  output logic                    Overflow,
  output logic [DW-1:0]           Peak,
  input  logic                    Clr
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] peak_q, peak_d, peak_base;
  logic [DW-1:0] yin_u, yin_mag;
  logic [DW-1:0] fifo_dout;
  logic          keep, pop, drop, full, empty;

  assign keep = In_en && (cnt_q == CW'(DECIM - 1));
  assign pop  = Dout_valid && Dout_ready;
  assign drop = keep && full && !pop;

  assign yin_u   = Yin;
  assign yin_mag = Yin[DW-1] ? ((~yin_u) + DW'(1)) : yin_u;

  // Clear applies first, so a push in the same cycle lands on the cleared values.
  assign peak_base = Clr ? '0 : peak_q;

  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = (Clr ? 1'b0 : ovf_q) | drop;
    peak_d = peak_base;
    if (In_en) cnt_d = (cnt_q == CW'(DECIM - 1)) ? '0 : cnt_q + CW'(1);
    if (keep && (yin_mag > peak_base)) peak_d = yin_mag;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      peak_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      peak_q <= peak_d;
    end
  end

  fir_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .push_i  (keep),
    .din_i   (yin_u),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .level_o (Level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign Dout       = fifo_dout;
  assign Dout_valid = !empty;
  assign Overflow   = ovf_q;
  assign Peak       = peak_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed bench for fir_out_buffer: one instance without decimation, one with DECIM=3.
module tb_fir_out_buffer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] yin, yin3;
  logic               in_en, in_en3;
  logic signed [15:0] dout, dout3;
  logic               dout_valid, dout_valid3;
  logic               dout_ready, dout_ready3;
  logic [3:0]         level, level3;
  logic               overflow, overflow3;
  logic [15:0]        peak, peak3;
  logic               clr, clr3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fir_out_buffer #(.DW(16), .DEPTH(8), .DECIM(1)) dut (
    .Clk(clk), .Rst_n(rst_n), .Yin(yin), .In_en(in_en), .Dout(dout),
    .Dout_valid(dout_valid), .Dout_ready(dout_ready), .Level(level),
    .Overflow(overflow), .Peak(peak), .Clr(clr)
  );

  fir_out_buffer #(.DW(16), .DEPTH(8), .DECIM(3)) dut3 (
    .Clk(clk), .Rst_n(rst_n), .Yin(yin3), .In_en(in_en3), .Dout(dout3),
    .Dout_valid(dout_valid3), .Dout_ready(dout_ready3), .Level(level3),
    .Overflow(overflow3), .Peak(peak3), .Clr(clr3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pass_v[8] = '{-3, 1, 0, -2, -1, 4, -5, 6};

  initial begin
    rst_n = 1'b0; yin = '0; in_en = 1'b0; dout_ready = 1'b0; clr = 1'b0;
    yin3 = '0; in_en3 = 1'b0; dout_ready3 = 1'b0; clr3 = 1'b0;
    step();
    check("reset_level", 16'(level), 16'd0);
    check("reset_valid", 16'(dout_valid), 16'd0);
    check("reset_dout", dout, 16'd0);
    check("reset_peak", peak, 16'd0);
    step();
    rst_n = 1'b1;

    // Passthrough with the consumer always ready
    dout_ready = 1'b1;
    in_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      yin = 16'(pass_v[i]);
      step();
      check($sformatf("pass_dout_%0d", i), dout, 16'(pass_v[i]));
      check($sformatf("pass_valid_%0d", i), 16'(dout_valid), 16'd1);
    end
    in_en = 1'b0;
    step();
    check("pass_level_end", 16'(level), 16'd0);
    check("pass_peak", peak, 16'd6);

    // Fill past full with the consumer stalled
    dout_ready = 1'b0;
    in_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      yin = 16'(i);
      step();
      if (i == 8) begin
        check("fill_level_8", 16'(level), 16'd8);
        check("fill_ovf_8", 16'(overflow), 16'd0);
      end
      if (i == 9) check("fill_ovf_9", 16'(overflow), 16'd1);
    end
    in_en = 1'b0;
    check("fill_level_10", 16'(level), 16'd8);
    check("fill_peak", peak, 16'd10);
    dout_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_dout_%0d", i), dout, 16'(i));
      step();
    end
    check("drain_level", 16'(level), 16'd0);
    check("drain_valid", 16'(dout_valid), 16'd0);
    check("drain_ovf_sticky", 16'(overflow), 16'd1);

    // Clear, then push and pop together while full
    dout_ready = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ovf", 16'(overflow), 16'd0);
    check("clr_peak", peak, 16'd0);
    in_en = 1'b1;
    for (int i = 11; i <= 18; i++) begin
      yin = 16'(i);
      step();
    end
    check("full_level", 16'(level), 16'd8);
    check("full_head", dout, 16'd11);
    dout_ready = 1'b1;
    for (int i = 19; i <= 21; i++) begin
      yin = 16'(i);
      step();
      check($sformatf("pp_level_%0d", i), 16'(level), 16'd8);
      check($sformatf("pp_head_%0d", i), dout, 16'(i - 7));
    end
    in_en = 1'b0;
    check("pp_ovf", 16'(overflow), 16'd0);
    for (int i = 14; i <= 21; i++) begin
      check($sformatf("pp_drain_%0d", i), dout, 16'(i));
      step();
    end
    check("pp_level_end", 16'(level), 16'd0);

    // Decimation by 3 with In_en held low mid-run
    for (int i = 0; i <= 8; i++) begin
      if (i == 4) begin
        in_en3 = 1'b0;
        yin3 = 16'd99;
        step();
        step();
      end
      in_en3 = 1'b1;
      yin3 = 16'(i);
      step();
      if (i == 2) check("decim_level_2", 16'(level3), 16'd1);
    end
    in_en3 = 1'b0;
    check("decim_level", 16'(level3), 16'd3);
    check("decim_peak", peak3, 16'd8);
    dout_ready3 = 1'b1;
    check("decim_out_0", dout3, 16'd2);
    step();
    check("decim_out_1", dout3, 16'd5);
    step();
    check("decim_out_2", dout3, 16'd8);
    step();
    check("decim_empty", 16'(dout_valid3), 16'd0);

    // Most negative sample, then Clr together with a push
    in_en = 1'b1;
    yin = 16'sh8000;
    step();
    in_en = 1'b0;
    check("peak_min_neg", peak, 16'h8000);
    check("dout_min_neg", dout, 16'h8000);
    step();
    dout_ready = 1'b0;
    in_en = 1'b1;
    yin = 16'd1;
    for (int i = 0; i < 9; i++) step();
    check("ovf_before_clr", 16'(overflow), 16'd1);
    dout_ready = 1'b1;
    clr = 1'b1;
    yin = 16'd7;
    step();
    check("clr_push_peak", peak, 16'd7);
    check("clr_push_ovf", 16'(overflow), 16'd0);
    check("clr_push_level", 16'(level), 16'd8);
    dout_ready = 1'b0;
    yin = 16'd3;
    step();
    clr = 1'b0;
    in_en = 1'b0;
    check("clr_drop_peak", peak, 16'd3);
    check("clr_drop_ovf", 16'(overflow), 16'd1);

    // Async reset with three entries queued
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    dout_ready = 1'b0;
    in_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      yin = 16'(40 + i);
      step();
    end
    in_en = 1'b0;
    check("pre_rst_level", 16'(level), 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", 16'(level), 16'd0);
    check("arst_valid", 16'(dout_valid), 16'd0);
    check("arst_ovf", 16'(overflow), 16'd0);
    check("arst_peak", peak, 16'd0);
    check("arst_dout", dout, 16'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
